// File: rtl/mips_pkg.sv
// Shared pipeline definitions: forwarding-mux select codes and the
// destination-register tag carried through EX/MEM/WB/RET.
package mips_pkg;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;
    localparam logic [1:0] FWD_RET   = 2'b11;

    // Tags carry a fixed-width register index; narrower REG_BITS are zero-extended.
    localparam int unsigned TAG_DST_BITS = 8;
    typedef logic [TAG_DST_BITS-1:0] dst_t;

    localparam dst_t REG_ZERO = '0;

    typedef struct packed {
        logic valid;
        dst_t dst;
        logic reg_write;
        logic mem_read;
    } tag_t;

    function automatic logic tag_live(input tag_t t);
        return t.valid & t.reg_write & (t.dst != REG_ZERO);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority comparator for one ALU operand: picks the youngest in-flight
// producer of the source register, as seen from the instruction in ID.
module fwd_select
    import mips_pkg::*;
(
    input  logic       use_src,
    input  dst_t       src,
    input  tag_t       ex_tag,
    input  tag_t       mem_tag,
    input  tag_t       wb_tag,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_REG;
        if (use_src && (src != REG_ZERO)) begin
            // A load in EX cannot forward yet; the pair stalls and is re-evaluated.
            if (tag_live(ex_tag) && (ex_tag.dst == src)) begin
                sel = ex_tag.mem_read ? FWD_REG : FWD_EXMEM;
            end else if (tag_live(mem_tag) && (mem_tag.dst == src)) begin
                sel = FWD_MEMWB;
            end else if (tag_live(wb_tag) && (wb_tag.dst == src)) begin
                sel = FWD_RET;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller for the 5-stage pipeline:
// destination tag pipeline, registered forward selects, stall/bubble and stall counter.
module fwd_hazard_unit
    import mips_pkg::*;
#(
    parameter int unsigned REG_BITS = 5,
    parameter int unsigned CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs,
    input  logic [REG_BITS-1:0] id_rt,
    input  logic                id_use_rs,
    input  logic                id_use_rt,
    input  logic [REG_BITS-1:0] id_dst,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                flush,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic                stall,
    output logic                bubble,
    output logic [CNT_BITS-1:0] stall_count
);

    tag_t ex_q, ex_d;
    tag_t mem_q, mem_d;
    tag_t wb_q, wb_d;
    tag_t ret_q, ret_d;
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    dst_t rs_w, rt_w, dst_w;
    logic [1:0] sel_a, sel_b;
    logic load_use;

    assign rs_w  = dst_t'(id_rs);
    assign rt_w  = dst_t'(id_rt);
    assign dst_w = dst_t'(id_dst);

    fwd_select u_sel_a (
        .use_src (id_use_rs),
        .src     (rs_w),
        .ex_tag  (ex_q),
        .mem_tag (mem_q),
        .wb_tag  (wb_q),
        .sel     (sel_a)
    );

    fwd_select u_sel_b (
        .use_src (id_use_rt),
        .src     (rt_w),
        .ex_tag  (ex_q),
        .mem_tag (mem_q),
        .wb_tag  (wb_q),
        .sel     (sel_b)
    );

    always_comb begin
        load_use = id_valid & tag_live(ex_q) & ex_q.mem_read &
                   ((id_use_rs & (rs_w == ex_q.dst)) |
                    (id_use_rt & (rt_w == ex_q.dst)));
        stall  = load_use & ~flush;
        bubble = stall | flush;
    end

    always_comb begin
        ret_d   = wb_q;
        wb_d    = mem_q;
        mem_d   = ex_q;
        ex_d    = '0;
        fwd_a_d = FWD_REG;
        fwd_b_d = FWD_REG;
        cnt_d   = cnt_q;
        if (!bubble && id_valid) begin
            ex_d.valid     = 1'b1;
            ex_d.dst       = dst_w;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            fwd_a_d        = sel_a;
            fwd_b_d        = sel_b;
        end
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            ret_q   <= '0;
            fwd_a_q <= FWD_REG;
            fwd_b_q <= FWD_REG;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= mem_d;
            wb_q    <= wb_d;
            ret_q   <= ret_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fwd_a       = fwd_a_q;
    assign fwd_b       = fwd_b_q;
    assign stall_count = cnt_q;

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Forwarding and load-use hazard controller for the 5-stage MIPS pipeline. It tracks the destination register of every in-flight instruction in its own tag pipeline (EX, MEM, WB, RET). It drives the 2-bit select codes consumed by the two 4:1 ALU-operand forwarding muxes, plus the stall/bubble controls for IF/ID. It produces the control that those muxes receive.

## Interface
Parameters:
- `REG_BITS`, default 5: register index width.
- `CNT_BITS`, default 16: stall statistics counter width.

Ports:
- `clk` in 1: pipeline clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs`, `id_rt` in `REG_BITS`: source registers of the ID instruction.
- `id_use_rs`, `id_use_rt` in 1: the instruction actually reads rs / rt.
- `id_dst` in `REG_BITS`: destination register of the ID instruction.
- `id_reg_write` in 1: the ID instruction writes `id_dst`.
- `id_mem_read` in 1: the ID instruction is a load.
- `flush` in 1: branch/jump redirect; the ID instruction is killed.
- `fwd_a`, `fwd_b` out 2: operand A / B select for the EX-stage muxes.
- `stall` out 1: hold PC and IF/ID this cycle.
- `bubble` out 1: the EX stage receives a NOP next cycle.
- `stall_count` out `CNT_BITS`: saturating count of load-use stalls.

## Operation
- Internal tag stages EX, MEM, WB, RET. Each stage holds {valid, dst, reg_write, mem_read}. A tag is live only when valid & reg_write & dst != 0.
- Shift: every cycle RET<=WB, WB<=MEM, MEM<=EX. EX<=ID tag, except on stall or flush, where EX<=invalid (bubble).
- Load-use hazard (combinational): `stall` = id_valid & !flush & EX.live & EX.mem_read & ((id_use_rs & id_rs==EX.dst) | (id_use_rt & id_rt==EX.dst)). `bubble` = stall | flush.
- Forward code for each operand, computed in ID and registered on the ID→EX edge. Matches are checked youngest first against the tags as they will be when the instruction sits in EX:
  - 01: match on current EX tag (value will be in EX/MEM).
  - 10: match on current MEM tag (value will be in MEM/WB).
  - 11: match on current WB tag (value retiring; regfile has no write-through).
  - 00: no match, or the source is $0, or the operand is unused.
- Mux mapping: 00→in1 regfile, 01→in2, 10→in3, 11→in4.
- When a bubble enters EX, `fwd_a`/`fwd_b` are registered as 00.
- A load matched at EX never yields 01. That case stalls instead. On the following cycle the load sits in MEM and the re-evaluation yields 10.
- `stall_count` increments once per stall cycle and saturates at all-ones.

## Timing
- Reset (async assert, sync release): all tags invalid, `fwd_a`=`fwd_b`=00, `stall_count`=0. `stall` and `bubble` read 0 because they derive from invalid tags, as long as `flush`=0.
- `fwd_*` latency: one cycle. Codes are valid throughout the EX cycle of the instruction they belong to.
- `stall` and `bubble` are combinational from the ID inputs and the EX tag, in the same cycle.
- A stall lasts exactly one cycle per load-use pair. Back-to-back dependent loads stall once each.
- `flush` with stall: flush wins. `stall`=0, `bubble`=1, and the counter does not increment.
- If `rst_n` is asserted mid-stall, everything clears immediately. No bubble remnants survive reset.
- Both operands may match different stages; each is resolved independently. rs==rt yields identical codes.

## Structure
- Shared package `mips_pkg`:
  - forward code constants FWD_REG=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, FWD_RET=2'b11.
  - tag struct typedef (valid, dst, reg_write, mem_read).
  - REG_ZERO constant.
- One sub-module is natural: `fwd_select`, a combinational priority comparator for one operand, instantiated twice (A, B).

## Test plan
- `add $3,$1,$2` then `sub $4,$3,$5`, no gap → `fwd_a`=01 in the sub's EX cycle, `stall`=0.
- Producer of $3 followed by one independent instruction, then a consumer of $3 in rt → `fwd_b`=10. With two independent instructions in between → `fwd_b`=11. With three → 00.
- `lw $6,0($1)` then `add $7,$6,$6` → one cycle with `stall`=1 and `bubble`=1. The next cycle gives `fwd_a`=`fwd_b`=10. `stall_count` becomes 1.
- Writes to $0 followed by reads of $0 → codes stay 00. A load to $0 followed by a use of $0 → no stall.
- Load-use hazard coincident with `flush`=1 → `stall`=0, `bubble`=1, counter unchanged. Next cycle, EX tag is invalid.
- `rst_n` pulsed low during a stall → outputs 00/0 asynchronously, `stall_count`=0. Force `stall_count` to all-ones, then trigger a stall → it stays at all-ones.
